bus_dma_copy: RTL and testbench
===============================

Name: bus_dma_copy

Overview:
- Memory-to-memory word-copy engine for the simple system.
- Exposes a device (responder) register port on the system bus, programmed by the core.
- Acts as a second bus host (initiator) that reads words from a source region and writes them to a destination region.
- Raises an interrupt on completion.

Parameters:
- DataWidth, 32, bus data width (only 32 supported)
- AddressWidth, 32, bus address width

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- dev_req_i  input  1  register access request
- dev_we_i  input  1  register write enable
- dev_be_i  input  4  register byte enables (ignored; full-word accesses)
- dev_addr_i  input  AddressWidth  register address (offset decoded from bits [9:2])
- dev_wdata_i  input  DataWidth  register write data
- dev_rvalid_o  output  1  register response valid
- dev_rdata_o  output  DataWidth  register read data
- dev_err_o  output  1  register access error
- host_req_o  output  1  bus request
- host_gnt_i  input  1  bus grant
- host_addr_o  output  AddressWidth  bus address
- host_we_o  output  1  bus write enable
- host_be_o  output  4  bus byte enables
- host_wdata_o  output  DataWidth  bus write data
- host_rvalid_i  input  1  bus response valid
- host_rdata_i  input  DataWidth  bus read data
- host_err_i  input  1  bus response error
- dma_intr_o  output  1  completion interrupt

Behaviour:
- Clocking/reset: one clock, clk_i. Reset is asynchronous, active-low on rst_ni.
- Outputs at reset: all outputs 0; registers 0; FSM in IDLE.
- Register map (offset = dev_addr_i[9:2]*4):
  - 0x00 SRC
  - 0x04 DST
  - 0x08 LEN (words remaining)
  - 0x0C CTRL: bit0 start (write-only, reads 0); bit1 irq_en
  - 0x10 STATUS: bit0 busy (RO); bit1 done (W1C); bit2 err (W1C)
- SRC/DST writes force bits [1:0] to 0.
- Device port timing:
  - Every dev_req_i is accepted in the same cycle.
  - dev_rvalid_o pulses exactly one cycle later, carrying dev_rdata_o (0 for writes).
  - Unmapped offsets: dev_err_o=1 alongside that rvalid; writes ignored; rdata 0.
- Writes while busy:
  - SRC/DST/LEN writes are ignored (still acknowledged, no error).
  - Start is ignored.
  - CTRL.irq_en remains writable.
- Register reads return live values, so SRC/DST/LEN reflect progress.
- Host FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
  - IDLE: on start with LEN!=0, clear done/err, go to RD_REQ. On start with LEN==0, set done next cycle with no bus traffic.
  - RD_REQ: host_req_o=1, we=0, be=4'hF, addr=SRC. Hold all signals stable until host_gnt_i. On gnt, go to RD_WAIT.
  - RD_WAIT: host_req_o=0. On host_rvalid_i, latch host_rdata_i into the data buffer.
    - If host_err_i: set err, go to IDLE.
    - Else go to WR_REQ.
  - WR_REQ: host_req_o=1, we=1, be=4'hF, addr=DST, wdata=buffer. Held until gnt, then go to WR_WAIT.
  - WR_WAIT: on host_rvalid_i:
    - If err: set err, go to IDLE; SRC/DST/LEN not updated.
    - Else SRC+=4, DST+=4, LEN-=1.
    - If new LEN==0: set done, go to IDLE. Else go to RD_REQ.
- Outstanding transactions: at most one; request deasserts in the cycle after gnt.
- host_req_o is registered (driven from FSM state).
- Minimum cost per word: 4 cycles with gnt same-cycle and rvalid next-cycle.
- Arithmetic: address increments wrap modulo 2^AddressWidth (0xFFFFFFFC+4 -> 0x0). LEN is 32-bit unsigned.
- Interrupt: busy = (state!=IDLE). dma_intr_o = (done|err) & irq_en, registered, level until W1C.
- Simultaneous events: hardware set of done/err in the same cycle as a W1C write wins (bit remains 1).
- Reset mid-transfer: host_req_o drops immediately (async), FSM returns to IDLE, no completion is signalled; any in-flight bus response afterwards is ignored.

Test Plan:
- SRC=0x100000, DST=0x100400, LEN=4, irq_en=1, start, gnt always 1, RAM rvalid next cycle -> 4 reads/4 writes alternating in order; destination matches source; STATUS=0x2 after 16 cycles; dma_intr_o=1; W1C 0x2 clears both.
- Same transfer with host_gnt_i stalled 3 cycles per request -> host_addr/we/wdata stable while req high; data correct; done set.
- LEN=0 start -> no host_req_o ever; done=1 one cycle after start; SRC/DST unchanged.
- Read error on word 2 (host_err_i=1) -> err=1, busy=0, LEN=2 (LEN=3 copy), SRC points at the failing word, no further bus requests.
- While busy: write LEN=99, write start, read 0x14 -> LEN unaffected, no restart, 0x14 access gets dev_err_o=1 with rvalid one cycle after req.
- Assert rst_ni low mid-WR_REQ -> host_req_o=0 immediately; after release all registers 0, STATUS=0, dma_intr_o=0.

Source files
------------

// File: rtl/bus_dma_copy.sv
// Word-copy DMA engine: register-programmed responder port plus a single-outstanding bus host
// that reads a source region and writes it to a destination region.
module bus_dma_copy #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    dev_req_i,
  input  logic                    dev_we_i,
  input  logic [3:0]              dev_be_i,
  input  logic [AddressWidth-1:0] dev_addr_i,
  input  logic [DataWidth-1:0]    dev_wdata_i,
  output logic                    dev_rvalid_o,
  output logic [DataWidth-1:0]    dev_rdata_o,
  output logic                    dev_err_o,
  output logic                    host_req_o,
  input  logic                    host_gnt_i,
  output logic [AddressWidth-1:0] host_addr_o,
  output logic                    host_we_o,
  output logic [3:0]              host_be_o,
  output logic [DataWidth-1:0]    host_wdata_o,
  input  logic                    host_rvalid_i,
  input  logic [DataWidth-1:0]    host_rdata_i,
  input  logic                    host_err_i,
  output logic                    dma_intr_o
);

  typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWrReq, StWrWait} state_e;

  localparam logic [7:0] OffSrc    = 8'h00;
  localparam logic [7:0] OffDst    = 8'h01;
  localparam logic [7:0] OffLen    = 8'h02;
  localparam logic [7:0] OffCtrl   = 8'h03;
  localparam logic [7:0] OffStatus = 8'h04;

  state_e                  state_q, state_d;
  logic [AddressWidth-1:0] src_q, src_d, dst_q, dst_d;
  logic [31:0]             len_q, len_d;
  logic [DataWidth-1:0]    buf_q, buf_d;
  logic                    irq_en_q, irq_en_d, done_q, done_d, err_q, err_d;
  logic                    rvalid_q, derr_q, derr_d, intr_q;
  logic [DataWidth-1:0]    rdata_q, rdata_d;

  logic [7:0] off;
  logic       busy, wr, start;
  logic       unused_bits;

  assign off   = dev_addr_i[9:2];
  assign busy  = (state_q != StIdle);
  assign wr    = dev_req_i & dev_we_i;
  assign start = wr & (off == OffCtrl) & dev_wdata_i[0] & ~busy;
  assign unused_bits = ^{dev_be_i, dev_addr_i[AddressWidth-1:10], dev_addr_i[1:0]};

  // Register read mux; values are sampled live so progress is visible mid-transfer.
  always_comb begin
    rdata_d = '0;
    derr_d  = dev_req_i & (off > OffStatus);
    if (dev_req_i && !dev_we_i) begin
      unique case (off)
        OffSrc:    rdata_d = DataWidth'(src_q);
        OffDst:    rdata_d = DataWidth'(dst_q);
        OffLen:    rdata_d = DataWidth'(len_q);
        OffCtrl:   rdata_d = {{(DataWidth-2){1'b0}}, irq_en_q, 1'b0};
        OffStatus: rdata_d = {{(DataWidth-3){1'b0}}, err_q, done_q, busy};
        default:   rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    buf_d    = buf_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    err_d    = err_q;

    if (wr) begin
      unique case (off)
        OffSrc:    if (!busy) src_d = {dev_wdata_i[AddressWidth-1:2], 2'b00};
        OffDst:    if (!busy) dst_d = {dev_wdata_i[AddressWidth-1:2], 2'b00};
        OffLen:    if (!busy) len_d = dev_wdata_i[31:0];
        OffCtrl:   irq_en_d = dev_wdata_i[1];
        OffStatus: begin
          if (dev_wdata_i[1]) done_d = 1'b0;
          if (dev_wdata_i[2]) err_d  = 1'b0;
        end
        default: ;
      endcase
    end

    // Hardware sets below override a same-cycle W1C above.
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len_q != 32'd0) begin
            done_d  = 1'b0;
            err_d   = 1'b0;
            state_d = StRdReq;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRdReq: if (host_gnt_i) state_d = StRdWait;
      StRdWait: begin
        if (host_rvalid_i) begin
          buf_d = host_rdata_i;
          if (host_err_i) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StWrReq;
          end
        end
      end
      StWrReq: if (host_gnt_i) state_d = StWrWait;
      StWrWait: begin
        if (host_rvalid_i) begin
          if (host_err_i) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            src_d = src_q + AddressWidth'(4);
            dst_d = dst_q + AddressWidth'(4);
            len_d = len_q - 32'd1;
            if (len_q == 32'd1) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = StRdReq;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      buf_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      derr_q   <= 1'b0;
      intr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      buf_q    <= buf_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rvalid_q <= dev_req_i;
      rdata_q  <= rdata_d;
      derr_q   <= derr_d;
      intr_q   <= (done_q | err_q) & irq_en_q;
    end
  end

  assign dev_rvalid_o = rvalid_q;
  assign dev_rdata_o  = rdata_q;
  assign dev_err_o    = derr_q;
  assign dma_intr_o   = intr_q;

  // Bus request decodes straight from the state flop so an async reset drops it at once.
  assign host_req_o   = (state_q == StRdReq) | (state_q == StWrReq);
  assign host_we_o    = (state_q == StWrReq);
  assign host_be_o    = host_req_o ? 4'hF : 4'h0;
  assign host_addr_o  = (state_q == StWrReq) ? dst_q : ((state_q == StRdReq) ? src_q : '0);
  assign host_wdata_o = host_we_o ? buf_q : '0;

endmodule

// File: tb/tb_bus_dma_copy.sv
// Directed bench for bus_dma_copy: register vectors from a table, then multi-cycle copy,
// stall, zero-length, wrap, error, busy-write and mid-transfer reset sequences.
module tb_bus_dma_copy;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dev_req = 1'b0, dev_we = 1'b0;
  logic [31:0] dev_addr = '0, dev_wdata = '0;
  logic        dev_rvalid, dev_err;
  logic [31:0] dev_rdata;
  logic        host_req, host_gnt, host_we, dma_intr;
  logic [31:0] host_addr, host_wdata;
  logic [3:0]  host_be;
  logic        bus_rvalid = 1'b0, bus_err = 1'b0;
  logic [31:0] bus_rdata = '0;

  always #5 clk = ~clk;

  bus_dma_copy dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .dev_req_i    (dev_req),
    .dev_we_i     (dev_we),
    .dev_be_i     (4'hF),
    .dev_addr_i   (dev_addr),
    .dev_wdata_i  (dev_wdata),
    .dev_rvalid_o (dev_rvalid),
    .dev_rdata_o  (dev_rdata),
    .dev_err_o    (dev_err),
    .host_req_o   (host_req),
    .host_gnt_i   (host_gnt),
    .host_addr_o  (host_addr),
    .host_we_o    (host_we),
    .host_be_o    (host_be),
    .host_wdata_o (host_wdata),
    .host_rvalid_i(bus_rvalid),
    .host_rdata_i (bus_rdata),
    .host_err_i   (bus_err),
    .dma_intr_o   (dma_intr)
  );

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h0F0F};
  endfunction

  // Bus responder: grant after stall_n waiting cycles, respond next cycle, log every grant.
  int unsigned stall_n = 0;
  int unsigned err_at  = 0;
  int unsigned wait_cnt = 0, rd_total = 0, log_n = 0;
  logic        log_we [256];
  logic [31:0] log_addr [256];
  logic [31:0] wmem [1024];
  logic        hold_q = 1'b0, gnt_q = 1'b0, viol = 1'b0;
  logic [31:0] hold_addr = '0, hold_wdata = '0;
  logic        hold_we = 1'b0;
  logic [3:0]  hold_be = '0;

  assign host_gnt = host_req && (wait_cnt >= stall_n);

  always @(posedge clk) begin
    bus_rvalid <= host_req && host_gnt;
    bus_err    <= 1'b0;
    bus_rdata  <= '0;
    if (host_req && host_gnt) begin
      log_we[log_n[7:0]]   <= host_we;
      log_addr[log_n[7:0]] <= host_addr;
      log_n <= log_n + 1;
      if (host_we) begin
        wmem[host_addr[11:2]] <= host_wdata;
      end else begin
        bus_rdata <= pat(host_addr);
        rd_total  <= rd_total + 1;
        bus_err   <= (rd_total + 1 == err_at);
      end
    end
    wait_cnt <= (host_req && !host_gnt) ? wait_cnt + 1 : 0;
    if (hold_q && host_req && (host_addr != hold_addr || host_we != hold_we ||
                               host_wdata != hold_wdata || host_be != hold_be))
      viol <= 1'b1;
    if (gnt_q && host_req) viol <= 1'b1;
    hold_q     <= host_req && !host_gnt;
    gnt_q      <= host_req && host_gnt;
    hold_addr  <= host_addr;
    hold_we    <= host_we;
    hold_wdata <= host_wdata;
    hold_be    <= host_be;
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic dev_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err);
    @(negedge clk);
    dev_req = 1'b1; dev_we = we; dev_addr = addr; dev_wdata = wdata;
    @(posedge clk); #1;
    dev_req = 1'b0; dev_we = 1'b0;
    check("dev_rvalid", {31'b0, dev_rvalid}, 32'd1);
    rdata = dev_rdata;
    err   = dev_err;
  endtask

  task automatic wr_reg(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    logic        e;
    dev_access(1'b1, addr, data, rd, e);
    check("wr_err", {31'b0, e}, 32'd0);
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        e;
    dev_access(1'b0, addr, 32'd0, rd, e);
    check(name, rd, exp);
    check({name, "_err"}, {31'b0, e}, 32'd0);
  endtask

  task automatic wait_intr(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (dma_intr) seen = 1;
    end
    check(name, {31'b0, seen}, 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int unsigned base;
    logic [31:0] rd;
    logic        e;
    bit          found;

    vecs[0]  = '{1'b0, 32'h000, 32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h010, 32'h0,        32'h0,        1'b0};
    vecs[2]  = '{1'b1, 32'h000, 32'h12345677, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h000, 32'h0,        32'h12345674, 1'b0};
    vecs[4]  = '{1'b1, 32'h004, 32'hABCDEF03, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'h004, 32'h0,        32'hABCDEF00, 1'b0};
    vecs[6]  = '{1'b1, 32'h008, 32'hFFFFFFFF, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 32'h008, 32'h0,        32'hFFFFFFFF, 1'b0};
    vecs[8]  = '{1'b1, 32'h00C, 32'h2,        32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'h00C, 32'h0,        32'h2,        1'b0};
    vecs[10] = '{1'b0, 32'h014, 32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b1, 32'h3FC, 32'h1,        32'h0,        1'b1};
    vecs[12] = '{1'b0, 32'h400, 32'h0,        32'h12345674, 1'b0};
    vecs[13] = '{1'b1, 32'h008, 32'h0,        32'h0,        1'b0};
    vecs[14] = '{1'b0, 32'h008, 32'h0,        32'h0,        1'b0};
    vecs[15] = '{1'b0, 32'h010, 32'h0,        32'h0,        1'b0};

    // Reset state
    #3;
    check("rst_host_req", {31'b0, host_req}, 32'd0);
    check("rst_rvalid", {31'b0, dev_rvalid}, 32'd0);
    check("rst_intr", {31'b0, dma_intr}, 32'd0);
    check("rst_host_addr", host_addr, 32'd0);
    check("rst_host_be", {28'b0, host_be}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      dev_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, e);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
    end

    // Basic 4-word copy, gnt immediate: exact 16-cycle completion
    wr_reg(32'h0, 32'h100000);
    wr_reg(32'h4, 32'h100400);
    wr_reg(32'h8, 32'd4);
    base = log_n;
    wr_reg(32'hC, 32'h3);
    repeat (15) @(posedge clk);
    rd_check("t1_status_busy", 32'h10, 32'h1);
    rd_check("t1_status_done", 32'h10, 32'h2);
    check("t1_intr", {31'b0, dma_intr}, 32'd1);
    check("t1_nxfer", log_n - base, 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_we%0d", i), {31'b0, log_we[base + i]}, i % 2);
      check($sformatf("t1_addr%0d", i), log_addr[base + i],
            (i % 2) ? 32'h100400 + 4 * (i / 2) : 32'h100000 + 4 * (i / 2));
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("t1_data%0d", i), wmem[10'h100 + i], pat(32'h100000 + 4 * i));
    rd_check("t1_src", 32'h0, 32'h100010);
    rd_check("t1_dst", 32'h4, 32'h100410);
    rd_check("t1_len", 32'h8, 32'h0);
    wr_reg(32'h10, 32'h2);
    repeat (2) @(posedge clk); #1;
    check("t1_intr_clr", {31'b0, dma_intr}, 32'd0);
    rd_check("t1_status_clr", 32'h10, 32'h0);

    // Same copy with 3 stall cycles per request
    stall_n = 3;
    wr_reg(32'h0, 32'h100000);
    wr_reg(32'h4, 32'h100800);
    wr_reg(32'h8, 32'd4);
    base = log_n;
    wr_reg(32'hC, 32'h3);
    wait_intr("t2_intr", 200);
    rd_check("t2_status", 32'h10, 32'h2);
    check("t2_nxfer", log_n - base, 32'd8);
    for (int i = 0; i < 4; i++)
      check($sformatf("t2_data%0d", i), wmem[10'h200 + i], pat(32'h100000 + 4 * i));
    wr_reg(32'h10, 32'h2);
    stall_n = 0;

    // Zero length start: done one cycle later, no traffic
    wr_reg(32'h0, 32'h200);
    wr_reg(32'h4, 32'h300);
    wr_reg(32'h8, 32'd0);
    base = log_n;
    wr_reg(32'hC, 32'h1);
    rd_check("t3_status", 32'h10, 32'h2);
    repeat (5) @(posedge clk); #1;
    check("t3_nxfer", log_n - base, 32'd0);
    check("t3_intr_off", {31'b0, dma_intr}, 32'd0);
    rd_check("t3_src", 32'h0, 32'h200);
    rd_check("t3_dst", 32'h4, 32'h300);
    wr_reg(32'h10, 32'h2);

    // Source address wraps past the top of the address space
    wr_reg(32'h0, 32'hFFFFFFFC);
    wr_reg(32'h4, 32'h600);
    wr_reg(32'h8, 32'd1);
    wr_reg(32'hC, 32'h1);
    repeat (8) @(posedge clk);
    rd_check("t3b_status", 32'h10, 32'h2);
    rd_check("t3b_src", 32'h0, 32'h0);
    rd_check("t3b_dst", 32'h4, 32'h604);
    check("t3b_data", wmem[10'h180], pat(32'hFFFFFFFC));
    wr_reg(32'h10, 32'h2);

    // Read error on the second word of a 3-word copy
    err_at = rd_total + 2;
    wr_reg(32'h0, 32'h100000);
    wr_reg(32'h4, 32'h100C00);
    wr_reg(32'h8, 32'd3);
    base = log_n;
    wr_reg(32'hC, 32'h3);
    wait_intr("t4_intr", 100);
    rd_check("t4_status", 32'h10, 32'h4);
    rd_check("t4_len", 32'h8, 32'd2);
    rd_check("t4_src", 32'h0, 32'h100004);
    rd_check("t4_dst", 32'h4, 32'h100C04);
    repeat (10) @(posedge clk); #1;
    check("t4_nxfer", log_n - base, 32'd3);
    wr_reg(32'h10, 32'h4);
    rd_check("t4_status_clr", 32'h10, 32'h0);
    err_at = 0;

    // Writes while busy: LEN and start ignored, unmapped access errors
    wr_reg(32'h0, 32'h100000);
    wr_reg(32'h4, 32'h101000);
    wr_reg(32'h8, 32'd4);
    base = log_n;
    wr_reg(32'hC, 32'h3);
    wr_reg(32'h8, 32'd99);
    wr_reg(32'hC, 32'h3);
    dev_access(1'b0, 32'h14, 32'h0, rd, e);
    check("t5_unmapped_err", {31'b0, e}, 32'd1);
    check("t5_unmapped_rdata", rd, 32'h0);
    @(posedge clk); #1;
    check("t5_rvalid_drop", {31'b0, dev_rvalid}, 32'd0);
    wait_intr("t5_intr", 100);
    rd_check("t5_len", 32'h8, 32'h0);
    rd_check("t5_src", 32'h0, 32'h100010);
    repeat (10) @(posedge clk); #1;
    check("t5_nxfer", log_n - base, 32'd8);
    check("t5_data3", wmem[10'h003], pat(32'h10000C));
    wr_reg(32'h10, 32'h2);

    check("bus_protocol", {31'b0, viol}, 32'd0);

    // Reset asserted while a write request is pending
    stall_n = 5;
    wr_reg(32'h0, 32'h100000);
    wr_reg(32'h4, 32'h102000);
    wr_reg(32'h8, 32'd2);
    wr_reg(32'hC, 32'h3);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk); #1;
      if (host_req && host_we) found = 1;
    end
    check("t6_wr_req_seen", {31'b0, found}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_req_drop", {31'b0, host_req}, 32'd0);
    check("t6_intr_rst", {31'b0, dma_intr}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    stall_n = 0;
    rd_check("t6_src", 32'h0, 32'h0);
    rd_check("t6_dst", 32'h4, 32'h0);
    rd_check("t6_len", 32'h8, 32'h0);
    rd_check("t6_ctrl", 32'hC, 32'h0);
    rd_check("t6_status", 32'h10, 32'h0);
    check("t6_intr", {31'b0, dma_intr}, 32'd0);
    check("t6_no_req", {31'b0, host_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
